// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pattern-mode encodings and the line/frame total helper.
package vga_pkg;

    // Counter width for both axes; totals up to 4096 fit.
    localparam int unsigned CNT_W = 12;

    // 640x480@60 reference timing.
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    // Pixel source selection on i_mode.
    localparam logic [1:0] MODE_EXT   = 2'b00;
    localparam logic [1:0] MODE_BARS  = 2'b01;
    localparam logic [1:0] MODE_CHECK = 2'b10;
    localparam logic [1:0] MODE_SOLID = 2'b11;

    // Total pixels per line or lines per frame.
    function automatic int unsigned calc_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync window and active-region decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE   = 640,
    parameter int unsigned FP       = 16,
    parameter int unsigned SYNC     = 96,
    parameter int unsigned BP       = 48,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap,
    output logic             o_sync,
    output logic             o_active
);

    localparam int unsigned      TOTAL      = calc_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);

    logic [CNT_W-1:0] r_cnt;
    logic             w_in_sync;

    // Position advances on each increment and wraps at the end of the axis.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    // Decode wrap, sync window and active region from the current position.
    always_comb begin
        o_wrap    = i_inc && (r_cnt == LAST);
        w_in_sync = (r_cnt >= SYNC_FIRST) && (r_cnt <= SYNC_LAST);
        o_sync    = w_in_sync ? SYNC_POL : ~SYNC_POL;
        o_active  = (r_cnt < ACT_END);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster engine: pixel divider, H/V counters, registered sync/blank/RGB outputs.
// Optional test-pattern source (bars/checker/solid) enabled by defining VGA_PATTERN_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned COLOR_W  = 1,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned NUM_BARS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_mode,
    input  logic [3*COLOR_W-1:0] i_rgb,
    output logic [CNT_W-1:0]     o_x,
    output logic [CNT_W-1:0]     o_y,
    output logic                 o_pix_en,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_blank,
    output logic                 o_frame_start,
    output logic [COLOR_W-1:0]   o_red,
    output logic [COLOR_W-1:0]   o_grn,
    output logic [COLOR_W-1:0]   o_blu
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]     r_div;
    logic                 w_pix_en;
    logic [CNT_W-1:0]     w_hcnt;
    logic [CNT_W-1:0]     w_vcnt;
    logic                 w_h_wrap;
    logic                 w_v_wrap;
    logic                 w_h_sync;
    logic                 w_v_sync;
    logic                 w_h_active;
    logic                 w_v_active;
    logic                 w_active;
    logic                 w_first;
    logic [3*COLOR_W-1:0] w_src;
    logic                 w_unused;
    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_blank;
    logic                 r_frame_start;
    logic [3*COLOR_W-1:0] r_rgb;

    // Pixel-clock divider; with CLK_DIV=1 it sits at 0 and the strobe stays high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= '0;
        end else begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    assign w_pix_en = (r_div == DIV_LAST);

    vga_axis_counter #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (SYNC_POL)
    ) u_h_axis (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_inc    (w_pix_en),
        .o_cnt    (w_hcnt),
        .o_wrap   (w_h_wrap),
        .o_sync   (w_h_sync),
        .o_active (w_h_active)
    );

    vga_axis_counter #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_v_axis (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_inc    (w_h_wrap),
        .o_cnt    (w_vcnt),
        .o_wrap   (w_v_wrap),
        .o_sync   (w_v_sync),
        .o_active (w_v_active)
    );

    assign w_active = w_h_active && w_v_active;
    assign w_first  = (w_hcnt == '0) && (w_vcnt == '0);

`ifdef VGA_PATTERN_EN
    localparam int unsigned      BAR_W    = H_ACTIVE / NUM_BARS;
    localparam int unsigned      KW       = (NUM_BARS > 8) ? $clog2(NUM_BARS) : 3;
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
    localparam logic [KW-1:0]    K_LAST   = KW'(NUM_BARS - 1);

    logic [1:0]       r_mode;
    logic [1:0]       w_mode;
    logic [CNT_W-1:0] r_bar_px;
    logic [KW-1:0]    r_bar_k;

    // The frame's first pixel already uses the mode being latched, so a frame never tears.
    assign w_mode = (w_pix_en && w_first) ? i_mode : r_mode;

    // Mode is captured only at pixel (0,0).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mode <= MODE_EXT;
        end else if (w_pix_en && w_first) begin
            r_mode <= i_mode;
        end
    end

    // Bar index steps every BAR_W active pixels and restarts at each line wrap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bar_px <= '0;
            r_bar_k  <= '0;
        end else if (w_pix_en) begin
            if (w_h_wrap) begin
                r_bar_px <= '0;
                r_bar_k  <= '0;
            end else if (w_h_active) begin
                if (r_bar_px == BAR_LAST) begin
                    r_bar_px <= '0;
                    if (r_bar_k != K_LAST) begin
                        r_bar_k <= r_bar_k + 1'b1;
                    end
                end else begin
                    r_bar_px <= r_bar_px + 1'b1;
                end
            end
        end
    end

    // Pixel source select.
    always_comb begin
        w_src = i_rgb;
        case (w_mode)
            MODE_BARS:  w_src = {{COLOR_W{r_bar_k[2]}}, {COLOR_W{r_bar_k[1]}},
                                 {COLOR_W{r_bar_k[0]}}};
            MODE_CHECK: w_src = {(3*COLOR_W){w_hcnt[5] ^ w_vcnt[5]}};
            MODE_SOLID: w_src = '1;
            default:    w_src = i_rgb;
        endcase
    end

    assign w_unused = w_v_wrap;
`else
    assign w_src    = i_rgb;
    assign w_unused = ^{i_mode, w_v_wrap, NUM_BARS};
`endif

    // Sync, blank and colour are registered together on the strobe so they stay aligned.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_blank <= 1'b1;
            r_rgb   <= '0;
        end else if (w_pix_en) begin
            r_hsync <= w_h_sync;
            r_vsync <= w_v_sync;
            r_blank <= ~w_active;
            r_rgb   <= w_active ? w_src : '0;
        end
    end

    // Frame start is refreshed every clock so it is one i_clk wide regardless of CLK_DIV.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_pix_en && w_first;
        end
    end

    assign o_x           = w_hcnt;
    assign o_y           = w_vcnt;
    assign o_pix_en      = w_pix_en;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_blank       = r_blank;
    assign o_frame_start = r_frame_start;
    assign o_red         = r_rgb[3*COLOR_W-1 -: COLOR_W];
    assign o_grn         = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign o_blu         = r_rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: two instances (divided/active-low/1-bit and
// undivided/active-high/4-bit) on a reduced raster, checked every clock against
// a pixel-index reference model. Pattern checks follow VGA_PATTERN_EN.
module tb_vga_timing_gen;

    localparam int HA = 64, HFP = 4, HS = 8, HBP = 4, HT = HA + HFP + HS + HBP;
    localparam int VA = 40, VFP = 2, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
    localparam int NB = 8;

    typedef struct {
        int         e;
        logic [1:0] fmode;
        logic       hs;
        logic       vs;
        logic       bl;
        logic [11:0] c;
    } mstate_t;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [2:0]  rgb0;
    logic [11:0] rgb1;

    logic [11:0] d0_x, d0_y, d1_x, d1_y;
    logic        d0_pe, d0_hs, d0_vs, d0_bl, d0_fs, d0_r, d0_g, d0_b;
    logic        d1_pe, d1_hs, d1_vs, d1_bl, d1_fs;
    logic [3:0]  d1_r, d1_g, d1_b;

    int n_checks = 0;
    int n_fail   = 0;

    mstate_t s0, s1;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .CLK_DIV (2), .COLOR_W (1), .SYNC_POL (1'b0), .NUM_BARS (NB)
    ) u_dut0 (
        .i_clk (clk), .i_rst (rst), .i_mode (mode), .i_rgb (rgb0),
        .o_x (d0_x), .o_y (d0_y), .o_pix_en (d0_pe), .o_hsync (d0_hs), .o_vsync (d0_vs),
        .o_blank (d0_bl), .o_frame_start (d0_fs), .o_red (d0_r), .o_grn (d0_g), .o_blu (d0_b)
    );

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .CLK_DIV (1), .COLOR_W (4), .SYNC_POL (1'b1), .NUM_BARS (NB)
    ) u_dut1 (
        .i_clk (clk), .i_rst (rst), .i_mode (mode), .i_rgb (rgb1),
        .o_x (d1_x), .o_y (d1_y), .o_pix_en (d1_pe), .o_hsync (d1_hs), .o_vsync (d1_vs),
        .o_blank (d1_bl), .o_frame_start (d1_fs), .o_red (d1_r), .o_grn (d1_g), .o_blu (d1_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [40:0] pk(input logic pe, input logic [11:0] x, input logic [11:0] y,
                                       input logic hs, input logic vs, input logic bl,
                                       input logic fs, input logic [11:0] c);
        return {pe, x, y, hs, vs, bl, fs, c};
    endfunction

    // Colour the spec prescribes for a visible pixel (qx,qy) in frame mode m.
    function automatic logic [11:0] exp_rgb(input int cw, input logic [1:0] m, input int qx,
                                            input int qy, input logic [11:0] cin);
        int ones, all;
        ones = (1 << cw) - 1;
        all  = (1 << (3 * cw)) - 1;
`ifdef VGA_PATTERN_EN
        begin
            int k;
            k = (qx / (HA / NB)) % 8;
            case (m)
                2'd1: return 12'((((k >> 2) & 1) * ones << (2 * cw)) |
                                 (((k >> 1) & 1) * ones << cw) | ((k & 1) * ones));
                2'd2: return 12'((((qx >> 5) ^ (qy >> 5)) & 1) * all);
                2'd3: return 12'(all);
                default: return cin & 12'(all);
            endcase
        end
`else
        if (m > 2'd3) return 12'd0;
        return cin & 12'(all);
`endif
    endfunction

    // Model: e = clock edges since reset release; strobes occur when e is a multiple of div,
    // each registering pixel index (e/div - 1) of the raster.
    task automatic model_step(input int div, input logic pol, input int cw, input logic r,
                              input logic [1:0] m, input logic [11:0] cin, inout mstate_t s,
                              output logic [40:0] ex);
        int p, q, qx, qy;
        logic fs;
        fs = 1'b0;
        if (r) begin
            s.e = 0; s.hs = ~pol; s.vs = ~pol; s.bl = 1'b1; s.c = 12'd0; s.fmode = 2'd0;
            ex = pk(logic'(div == 1), 12'd0, 12'd0, ~pol, ~pol, 1'b1, 1'b0, 12'd0);
        end else begin
            s.e++;
            if (s.e % div == 0) begin
                q  = s.e / div - 1;
                qx = q % HT;
                qy = (q / HT) % VT;
                if (qx == 0 && qy == 0) s.fmode = m;
                s.bl = !(qx < HA && qy < VA);
                s.hs = (qx >= HA + HFP && qx < HA + HFP + HS) ? pol : ~pol;
                s.vs = (qy >= VA + VFP && qy < VA + VFP + VS) ? pol : ~pol;
                s.c  = s.bl ? 12'd0 : exp_rgb(cw, s.fmode, qx, qy, cin);
                fs   = (qx == 0 && qy == 0);
            end
            p  = s.e / div;
            ex = pk(logic'(s.e % div == div - 1), 12'(p % HT), 12'((p / HT) % VT),
                    s.hs, s.vs, s.bl, fs, s.c);
        end
    endtask

    // One clock: sample after the edge, check both DUTs, then re-randomize colour at negedge.
    task automatic tick();
        logic [40:0] ex0, ex1;
        @(posedge clk);
        #1;
        model_step(2, 1'b0, 1, rst, mode, {9'd0, rgb0}, s0, ex0);
        model_step(1, 1'b1, 4, rst, mode, rgb1, s1, ex1);
        check_eq("d0_cycle", 64'(pk(d0_pe, d0_x, d0_y, d0_hs, d0_vs, d0_bl, d0_fs,
                                    {9'd0, d0_r, d0_g, d0_b})), 64'(ex0));
        check_eq("d1_cycle", 64'(pk(d1_pe, d1_x, d1_y, d1_hs, d1_vs, d1_bl, d1_fs,
                                    {d1_r, d1_g, d1_b})), 64'(ex1));
        @(negedge clk);
        rgb0 = 3'($urandom);
        rgb1 = 12'($urandom);
    endtask

    function automatic logic get_sig(input int which);
        case (which)
            0:       return d0_hs;
            1:       return d0_vs;
            2:       return d0_fs;
            default: return d1_hs;
        endcase
    endfunction

    // Clocks until the selected signal reaches lvl; stops at limit.
    task automatic wait_for(input int which, input logic lvl, input int limit, output int n);
        n = 0;
        while (get_sig(which) !== lvl && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, w, n2, lim;
        rst  = 1'b1;
        mode = 2'd0;
        rgb0 = 3'd0;
        rgb1 = 12'd0;
        repeat (4) tick();
        rst = 1'b0;

        // External source, random colour, just over one slow frame.
        repeat (HT * VT * 2 + 50) tick();

        // Timing measurements.
        wait_for(0, 1'b0, 2000, n);
        wait_for(0, 1'b1, 2000, w);
        check_eq("d0_hsync_width", 64'(w), 64'(HS * 2));
        wait_for(0, 1'b0, 2000, n2);
        check_eq("d0_line_period", 64'(w + n2), 64'(HT * 2));
        wait_for(1, 1'b0, 20000, n);
        wait_for(1, 1'b1, 20000, w);
        check_eq("d0_vsync_width", 64'(w), 64'(VS * HT * 2));
        wait_for(2, 1'b1, 20000, n);
        wait_for(2, 1'b0, 10, w);
        check_eq("d0_fs_width", 64'(w), 64'd1);
        wait_for(2, 1'b1, 20000, n2);
        check_eq("d0_frame_period", 64'(w + n2), 64'(HT * VT * 2));
        wait_for(3, 1'b1, 2000, n);
        wait_for(3, 1'b0, 2000, w);
        check_eq("d1_hsync_width", 64'(w), 64'(HS));

        // Bars, switched to checker mid-frame; the change must wait for the next frame.
        mode = 2'd1;
        lim  = 0;
        while (d0_y != 12'd20 && lim < 20000) begin
            tick();
            lim++;
        end
        check_eq("wait_y20", 64'(lim < 20000), 64'd1);
        mode = 2'd2;
        repeat (HT * VT * 2 * 2) tick();

        // Solid white.
        mode = 2'd3;
        repeat (HT * VT * 2 + 100) tick();

        // Reset in mid-frame: async effect, then restart from (0,0).
        mode = 2'd0;
        lim  = 0;
        while (!(d0_x == 12'd30 && d0_y == 12'd10) && lim < 20000) begin
            tick();
            lim++;
        end
        check_eq("wait_x30_y10", 64'(lim < 20000), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("d0_async_rst", 64'(pk(d0_pe, d0_x, d0_y, d0_hs, d0_vs, d0_bl, d0_fs,
                                        {9'd0, d0_r, d0_g, d0_b})),
                 64'(pk(1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0)));
        check_eq("d1_async_rst", 64'(pk(d1_pe, d1_x, d1_y, d1_hs, d1_vs, d1_bl, d1_fs,
                                        {d1_r, d1_g, d1_b})),
                 64'(pk(1'b1, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0)));
        repeat (3) tick();
        rst = 1'b0;
        wait_for(2, 1'b1, 100, n);
        check_eq("d0_fs_after_rst", 64'(n), 64'd2);
        mode = 2'(($urandom % 3) + 1);
        repeat (HT * VT * 2 + 50) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
